// File: rtl/maze_rx_controller.sv
// Maze tile memory write sequencer: converts the synchronized parallel-port byte
// stream into row/column write commands and runs the hardware clear sweep.
module maze_rx_controller #(
    parameter int ROWS     = 10,
    parameter int COLS     = 10,
    parameter int MEM_COLS = 14,
    parameter int TIMEOUT  = 25000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        strobe,
    input  logic        new_frame,
    input  logic [7:0]  data_in,
    input  logic        clear_req,
    output logic        wr_en,
    output logic [3:0]  wr_row,
    output logic [3:0]  wr_col,
    output logic [7:0]  wr_data,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_cnt,
    output logic [7:0]  err_cnt
);

    localparam int              TW        = $clog2(TIMEOUT + 1);
    localparam logic [3:0]      ROW_LAST  = 4'(ROWS - 1);
    localparam logic [3:0]      COL_LAST  = 4'(COLS - 1);
    localparam logic [3:0]      MCOL_LAST = 4'(MEM_COLS - 1);
    localparam logic [TW-1:0]   TO_LAST   = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_RECV  = 2'd2
    } state_t;

    state_t         state_q;
    logic           strobe_prev_q;
    logic           clear_prev_q;
    logic [3:0]     row_q;
    logic [3:0]     col_q;
    logic [3:0]     sw_row_q;
    logic [3:0]     sw_col_q;
    logic [TW-1:0]  to_cnt_q;
    logic           done_pend_q;
    logic           wr_en_q;
    logic [3:0]     wr_row_q;
    logic [3:0]     wr_col_q;
    logic [7:0]     wr_data_q;
    logic           busy_q;
    logic           frame_done_q;
    logic [15:0]    frame_cnt_q;
    logic [7:0]     err_cnt_q;

    logic           strobe_edge_s;
    logic           clear_edge_s;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign strobe_edge_s = strobe & ~strobe_prev_q;
    assign clear_edge_s  = clear_req & ~clear_prev_q;

    // Main sequencer: clear sweep, byte placement, framing recovery and counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_CLEAR;
            strobe_prev_q <= 1'b0;
            clear_prev_q  <= 1'b0;
            row_q         <= 4'd0;
            col_q         <= 4'd0;
            sw_row_q      <= 4'd0;
            sw_col_q      <= 4'd0;
            to_cnt_q      <= '0;
            done_pend_q   <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_row_q      <= 4'd0;
            wr_col_q      <= 4'd0;
            wr_data_q     <= 8'd0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_cnt_q   <= 16'd0;
            err_cnt_q     <= 8'd0;
        end else begin
            strobe_prev_q <= strobe;
            clear_prev_q  <= clear_req;
            wr_en_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_pend_q   <= 1'b0;
            frame_done_q  <= done_pend_q;
            if (done_pend_q) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            case (state_q)
                ST_CLEAR: begin
                    wr_en_q   <= 1'b1;
                    wr_row_q  <= sw_row_q;
                    wr_col_q  <= sw_col_q;
                    wr_data_q <= 8'h00;
                    busy_q    <= 1'b1;
                    to_cnt_q  <= '0;
                    row_q     <= 4'd0;
                    col_q     <= 4'd0;
                    if (sw_col_q == MCOL_LAST) begin
                        sw_col_q <= 4'd0;
                        if (sw_row_q == ROW_LAST) begin
                            sw_row_q <= 4'd0;
                            state_q  <= ST_IDLE;
                        end else begin
                            sw_row_q <= sw_row_q + 4'd1;
                        end
                    end else begin
                        sw_col_q <= sw_col_q + 4'd1;
                    end
                end
                ST_IDLE, ST_RECV: begin
                    // A clear request outranks a byte arriving in the same cycle.
                    if (clear_edge_s) begin
                        state_q  <= ST_CLEAR;
                        sw_row_q <= 4'd0;
                        sw_col_q <= 4'd0;
                        row_q    <= 4'd0;
                        col_q    <= 4'd0;
                        to_cnt_q <= '0;
                    end else if (strobe_edge_s) begin
                        wr_en_q   <= 1'b1;
                        wr_data_q <= data_in;
                        to_cnt_q  <= '0;
                        if (new_frame) begin
                            wr_row_q <= 4'd0;
                            wr_col_q <= 4'd0;
                            row_q    <= 4'd0;
                            col_q    <= 4'd1;
                            state_q  <= ST_RECV;
                            if (state_q == ST_RECV) begin
                                err_cnt_q <= sat_inc8(err_cnt_q);
                            end
                        end else begin
                            wr_row_q <= row_q;
                            wr_col_q <= col_q;
                            if ((row_q == ROW_LAST) && (col_q == COL_LAST)) begin
                                row_q       <= 4'd0;
                                col_q       <= 4'd0;
                                done_pend_q <= 1'b1;
                                state_q     <= ST_IDLE;
                            end else begin
                                state_q <= ST_RECV;
                                if (col_q == COL_LAST) begin
                                    col_q <= 4'd0;
                                    row_q <= row_q + 4'd1;
                                end else begin
                                    col_q <= col_q + 4'd1;
                                end
                            end
                        end
                    end else if (state_q == ST_RECV) begin
                        // Stalled mid-frame: drop the partial frame and wait for a new one.
                        if (to_cnt_q == TO_LAST) begin
                            to_cnt_q  <= '0;
                            row_q     <= 4'd0;
                            col_q     <= 4'd0;
                            err_cnt_q <= sat_inc8(err_cnt_q);
                            state_q   <= ST_IDLE;
                        end else begin
                            to_cnt_q <= to_cnt_q + TW'(1);
                        end
                    end else begin
                        to_cnt_q <= '0;
                    end
                end
                default: begin
                    state_q  <= ST_CLEAR;
                    sw_row_q <= 4'd0;
                    sw_col_q <= 4'd0;
                    row_q    <= 4'd0;
                    col_q    <= 4'd0;
                    to_cnt_q <= '0;
                end
            endcase
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_row     = wr_row_q;
    assign wr_col     = wr_col_q;
    assign wr_data    = wr_data_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_maze_rx_controller.sv
// Randomized bench for maze_rx_controller; expectations come from an index-based
// frame model (byte index -> row = idx / COLS, col = idx % COLS).
module tb_maze_rx_controller;

    localparam int ROWS     = 10;
    localparam int COLS     = 10;
    localparam int MEM_COLS = 14;
    localparam int TIMEOUT  = 25000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        strobe = 1'b0;
    logic        new_frame = 1'b0;
    logic [7:0]  data_in = 8'd0;
    logic        clear_req = 1'b0;
    logic        wr_en;
    logic [3:0]  wr_row;
    logic [3:0]  wr_col;
    logic [7:0]  wr_data;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;

    maze_rx_controller #(
        .ROWS(ROWS), .COLS(COLS), .MEM_COLS(MEM_COLS), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .strobe(strobe), .new_frame(new_frame),
        .data_in(data_in), .clear_req(clear_req), .wr_en(wr_en),
        .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data), .busy(busy),
        .frame_done(frame_done), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Write monitor, sampled on the falling edge.
    logic [15:0] wq[$];
    int          wcyc[$];
    int          fdcyc[$];
    int          busy_n = 0;
    always @(negedge clk) begin
        if (wr_en) begin
            wq.push_back({wr_row, wr_col, wr_data});
            wcyc.push_back(cyc);
        end
        if (frame_done) fdcyc.push_back(cyc);
        if (busy) busy_n++;
    end

    int errors = 0;
    int checks = 0;

    // Reference model.
    int          m_idx = 0;
    int          m_err = 0;
    int          m_frames = 0;
    logic [15:0] expq[$];

    function automatic void m_byte(input bit nf, input logic [7:0] d);
        if (nf) begin
            expq.push_back({4'd0, 4'd0, d});
            if (m_idx != 0 && m_err < 255) m_err++;
            m_idx = 1;
        end else begin
            expq.push_back({4'(m_idx / COLS), 4'(m_idx % COLS), d});
            m_idx++;
            if (m_idx == ROWS * COLS) begin
                m_idx = 0;
                m_frames++;
            end
        end
    endfunction

    function automatic void m_clear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < MEM_COLS; c++)
                expq.push_back({4'(r), 4'(c), 8'h00});
        m_idx = 0;
    endfunction

    function automatic void clear_logs();
        wq.delete(); wcyc.delete(); fdcyc.delete(); expq.delete();
        busy_n = 0;
    endfunction

    // Drive one byte: strobe high for hi cycles then low for lo cycles.
    task automatic send(input bit nf, input logic [7:0] d, input int hi, input int lo);
        strobe = 1'b1; new_frame = nf; data_in = d;
        m_byte(nf, d);
        repeat (hi) @(posedge clk);
        #1; strobe = 1'b0; new_frame = 1'b0;
        repeat (lo) @(posedge clk);
        #1;
    endtask

    task automatic send_rand(input bit nf);
        send(nf, 8'($urandom), $urandom_range(1, 3), $urandom_range(1, 4));
    endtask

    task automatic test_reset();
        int rel;
        @(posedge clk); #1;
        rst = 1'b0; strobe = 1'b0; new_frame = 1'b0; clear_req = 1'b0;
        repeat (3) @(posedge clk); #1;
        checks++;
        if ({wr_en, busy, frame_done, frame_cnt, err_cnt, wr_row, wr_col, wr_data} !== 44'd0) begin
            errors++;
            $display("FAIL reset_outputs: got en=%b busy=%b fd=%b fc=%0d ec=%0d r=%0d c=%0d d=%0h expected all zero",
                     wr_en, busy, frame_done, frame_cnt, err_cnt, wr_row, wr_col, wr_data);
        end
        m_idx = 0; m_err = 0; m_frames = 0;
        clear_logs();
        rel = cyc;
        rst = 1'b1;
        m_clear();
        repeat (150) @(posedge clk); #1;
        checks++;
        if (wq.size() != ROWS * MEM_COLS) begin
            errors++;
            $display("FAIL reset_sweep_count: got %0d writes expected %0d", wq.size(), ROWS * MEM_COLS);
        end
        for (int i = 0; i < wq.size() && i < expq.size(); i++) begin
            checks++;
            if (wq[i] !== expq[i] || wcyc[i] != rel + 1 + i) begin
                errors++;
                $display("FAIL reset_sweep_write[%0d]: got %h at cycle %0d expected %h at cycle %0d",
                         i, wq[i], wcyc[i], expq[i], rel + 1 + i);
            end
        end
        checks++;
        if (busy_n != ROWS * MEM_COLS || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %0d busy cycles (now %b) expected %0d (now 0)", busy_n, busy, ROWS * MEM_COLS);
        end
    endtask

    task automatic test_frame_index();
        int f0 = m_frames;
        clear_logs();
        for (int i = 0; i < ROWS * COLS; i++) send(i == 0, 8'(i), 2, 2);
        repeat (3) @(posedge clk); #1;
        checks++;
        if (wq.size() != expq.size()) begin
            errors++;
            $display("FAIL frame_index_count: got %0d writes expected %0d", wq.size(), expq.size());
        end
        for (int i = 0; i < wq.size() && i < expq.size(); i++) begin
            checks++;
            if (wq[i] !== expq[i]) begin
                errors++;
                $display("FAIL frame_index_write[%0d]: got %h expected %h", i, wq[i], expq[i]);
            end
        end
        checks++;
        if (wq.size() > 37 && wq[37] !== {4'd3, 4'd7, 8'h25}) begin
            errors++;
            $display("FAIL frame_byte37: got %h expected 3725", wq[37]);
        end
        checks++;
        if (fdcyc.size() != m_frames - f0 || wcyc.size() < 100 || fdcyc.size() < 1 || fdcyc[0] != wcyc[99] + 1) begin
            errors++;
            $display("FAIL frame_done_timing: got %0d pulses expected %0d one cycle after last write",
                     fdcyc.size(), m_frames - f0);
        end
        checks++;
        if (frame_cnt !== 16'(m_frames) || err_cnt !== 8'(m_err)) begin
            errors++;
            $display("FAIL frame_counters: got fc=%0d ec=%0d expected fc=%0d ec=%0d", frame_cnt, err_cnt, m_frames, m_err);
        end
    endtask

    task automatic test_random_frames();
        int f0 = m_frames;
        clear_logs();
        for (int f = 0; f < 3; f++)
            for (int i = 0; i < ROWS * COLS; i++)
                send_rand(i == 0 ? 1'($urandom) : 1'b0);
        repeat (3) @(posedge clk); #1;
        checks++;
        if (wq.size() != expq.size()) begin
            errors++;
            $display("FAIL random_count: got %0d writes expected %0d", wq.size(), expq.size());
        end
        for (int i = 0; i < wq.size() && i < expq.size(); i++) begin
            checks++;
            if (wq[i] !== expq[i]) begin
                errors++;
                $display("FAIL random_write[%0d]: got %h expected %h", i, wq[i], expq[i]);
            end
        end
        checks++;
        if (fdcyc.size() != m_frames - f0 || frame_cnt !== 16'(m_frames) || err_cnt !== 8'(m_err)) begin
            errors++;
            $display("FAIL random_counters: got fd=%0d fc=%0d ec=%0d expected fd=%0d fc=%0d ec=%0d",
                     fdcyc.size(), frame_cnt, err_cnt, m_frames - f0, m_frames, m_err);
        end
    endtask

    task automatic test_resync();
        int e0 = m_err;
        clear_logs();
        for (int i = 0; i < 41; i++) send_rand(i == 0);
        send_rand(1'b1);
        for (int i = 0; i < 98; i++) send_rand(1'b0);
        repeat (3) @(posedge clk); #1;
        checks++;
        if (err_cnt !== 8'(m_err) || m_err != e0 + 1) begin
            errors++;
            $display("FAIL resync_err: got %0d expected %0d", err_cnt, e0 + 1);
        end
        checks++;
        if (wq.size() > 42 && (wq[41][15:8] !== 8'h00 || wq[42][15:8] !== 8'h01)) begin
            errors++;
            $display("FAIL resync_addr: got %h,%h expected rows/cols 00,01", wq[41][15:8], wq[42][15:8]);
        end
        for (int i = 0; i < wq.size() && i < expq.size(); i++) begin
            checks++;
            if (wq[i] !== expq[i]) begin
                errors++;
                $display("FAIL resync_write[%0d]: got %h expected %h", i, wq[i], expq[i]);
            end
        end
        checks++;
        if (wq.size() != expq.size() || frame_cnt !== 16'(m_frames)) begin
            errors++;
            $display("FAIL resync_totals: got %0d writes fc=%0d expected %0d writes fc=%0d",
                     wq.size(), frame_cnt, expq.size(), m_frames);
        end
    endtask

    task automatic test_timeout();
        int n0;
        clear_logs();
        for (int i = 0; i < 51; i++) send_rand(i == 0);
        repeat (TIMEOUT - 100) @(posedge clk); #1;
        checks++;
        if (err_cnt !== 8'(m_err)) begin
            errors++;
            $display("FAIL timeout_short_stall: got err %0d expected %0d", err_cnt, m_err);
        end
        send_rand(1'b0);
        n0 = wq.size();
        repeat (TIMEOUT + 20) @(posedge clk); #1;
        m_idx = 0;
        if (m_err < 255) m_err++;
        checks++;
        if (err_cnt !== 8'(m_err) || wq.size() != n0) begin
            errors++;
            $display("FAIL timeout_abort: got err %0d writes %0d expected err %0d writes %0d",
                     err_cnt, wq.size(), m_err, n0);
        end
        for (int i = 0; i < ROWS * COLS; i++) send_rand(1'b0);
        repeat (3) @(posedge clk); #1;
        checks++;
        if (wq.size() != expq.size() || wq.size() <= n0 || wq[n0][15:8] !== 8'h00 || frame_cnt !== 16'(m_frames)) begin
            errors++;
            $display("FAIL timeout_recover: got %0d writes fc=%0d expected %0d writes fc=%0d first at 00",
                     wq.size(), frame_cnt, expq.size(), m_frames);
        end
        for (int i = 0; i < wq.size() && i < expq.size(); i++) begin
            checks++;
            if (wq[i] !== expq[i]) begin
                errors++;
                $display("FAIL timeout_write[%0d]: got %h expected %h", i, wq[i], expq[i]);
            end
        end
    endtask

    task automatic test_clear_arb();
        int n0;
        int c0;
        int e0;
        clear_logs();
        for (int i = 0; i < 10; i++) send_rand(i == 0);
        e0 = m_err;
        n0 = wq.size();
        strobe = 1'b1; new_frame = 1'b1; data_in = 8'hAA; clear_req = 1'b1;
        c0 = cyc + 1;
        m_clear();
        @(posedge clk); #1;
        for (int k = 0; k < 116; k++) begin
            strobe = (k % 2 == 1); new_frame = 1'($urandom); data_in = 8'($urandom);
            @(posedge clk); #1;
        end
        strobe = 1'b0; new_frame = 1'b0;
        repeat (40) @(posedge clk); #1;
        checks++;
        if (wq.size() - n0 != ROWS * MEM_COLS || busy_n != ROWS * MEM_COLS) begin
            errors++;
            $display("FAIL clear_arb_count: got %0d writes %0d busy expected %0d", wq.size() - n0, busy_n, ROWS * MEM_COLS);
        end
        for (int i = 0; i < wq.size() && i < expq.size(); i++) begin
            checks++;
            if (wq[i] !== expq[i] || (i >= n0 && wcyc[i] != c0 + 1 + i - n0)) begin
                errors++;
                $display("FAIL clear_arb_write[%0d]: got %h at %0d expected %h", i, wq[i], wcyc[i], expq[i]);
            end
        end
        checks++;
        if (err_cnt !== 8'(e0)) begin
            errors++;
            $display("FAIL clear_arb_err: got %0d expected %0d", err_cnt, e0);
        end
        n0 = wq.size();
        send_rand(1'b1);
        repeat (20) @(posedge clk); #1;
        checks++;
        if (wq.size() != n0 + 1 || wq[n0] !== expq[n0] || err_cnt !== 8'(m_err)) begin
            errors++;
            $display("FAIL clear_held_high: got %0d writes err %0d expected %0d writes err %0d",
                     wq.size(), err_cnt, n0 + 1, m_err);
        end
        clear_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_err_saturate();
        clear_logs();
        send_rand(1'b1);
        for (int i = 0; i < 300; i++) begin
            send(1'b0, 8'($urandom), 1, 1);
            send(1'b1, 8'($urandom), 1, 1);
        end
        repeat (3) @(posedge clk); #1;
        checks++;
        if (err_cnt !== 8'(m_err) || m_err != 255) begin
            errors++;
            $display("FAIL err_saturate: got %0d expected %0d", err_cnt, m_err);
        end
        checks++;
        if (wq.size() != expq.size()) begin
            errors++;
            $display("FAIL err_sat_count: got %0d writes expected %0d", wq.size(), expq.size());
        end
        for (int i = 0; i < wq.size() && i < expq.size(); i++) begin
            checks++;
            if (wq[i] !== expq[i]) begin
                errors++;
                $display("FAIL err_sat_write[%0d]: got %h expected %h", i, wq[i], expq[i]);
            end
        end
    endtask

    task automatic test_reset_midsweep();
        clear_req = 1'b1;
        repeat (60) @(posedge clk); #1;
        test_reset();
        clear_logs();
        send_rand(1'b0);
        repeat (3) @(posedge clk); #1;
        checks++;
        if (wq.size() != 1 || wq[0] !== expq[0] || err_cnt !== 8'd0 || frame_cnt !== 16'd0) begin
            errors++;
            $display("FAIL post_reset_byte: got %0d writes ec=%0d fc=%0d expected 1 write %h, zero counters",
                     wq.size(), err_cnt, frame_cnt, expq[0]);
        end
    endtask

    initial begin
        test_reset();
        test_frame_index();
        test_random_frames();
        test_resync();
        test_timeout();
        test_clear_arb();
        test_err_saturate();
        test_reset_midsweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/maze_rx_controller.md
Name: maze_rx_controller

Overview:
Sequences all writes into the 10x14 maze tile memory of the base-station display. Receives the synchronized parallel-port byte stream (strobe, new-frame flag, data) and converts it into single-cycle row/column write commands. Owns start-up and on-demand memory clearing as a hardware sweep, arbitrated against incoming bytes. Detects framing faults (early new-frame, stalled transmission) and recovers. Sits between the port synchronizer and the maze memory, in the pixel-clock domain.

Parameters:
ROWS, 10, maze rows carried per frame
COLS, 10, maze columns carried per frame (bytes per frame = ROWS*COLS)
MEM_COLS, 14, physical memory columns swept by a clear (MEM_COLS >= COLS)
TIMEOUT, 25000, clk cycles without a strobe edge mid-frame before abort (1 ms at 25.17 MHz)

Ports:
clk  in  1  pixel clock, all logic on rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
strobe  in  1  synchronized Arduino byte clock, data valid on rising edge
new_frame  in  1  synchronized start-of-frame flag, sampled with the strobe edge
data_in  in  8  synchronized tile byte
clear_req  in  1  level request to zero the whole memory
wr_en  out  1  memory write enable, one-cycle pulse
wr_row  out  4  write row address
wr_col  out  4  write column address
wr_data  out  8  write data
busy  out  1  high while a clear sweep is in progress
frame_done  out  1  one-cycle pulse after the last byte of a frame is written
frame_cnt  out  16  completed frames, wraps
err_cnt  out  8  framing errors, saturates at 255

Behaviour:
- Reset (rst=0, async): all outputs 0, index 0, prev_strobe 0, state CLEAR armed; on release the FSM enters CLEAR at the first clk edge.
- Edge detect: edge = strobe & ~prev_strobe; prev_strobe updates every cycle, including in CLEAR.
- States: CLEAR, IDLE (index 0, waiting), RECV (index != 0).
- CLEAR:
  - Writes 0x00 to every cell, row-major, row 0..ROWS-1, col 0..MEM_COLS-1, one write per cycle.
  - ROWS*MEM_COLS = 140 consecutive wr_en pulses; busy=1 throughout.
  - Strobe edges during CLEAR are dropped, with no error count.
  - After the last cell: busy=0, index 0, go to IDLE.
  - clear_req held high re-enters CLEAR only after it goes low and high again (edge-triggered on a 0->1 transition).
- Clear arbitration: a clear_req rising edge in IDLE/RECV wins over a simultaneous strobe edge. That byte is dropped, and the first clear write happens the next cycle.
- Byte write:
  - On the cycle edge is detected, registered outputs update at that clk edge: wr_en=1 for exactly one cycle, wr_data=data_in, address from index.
  - Latency is one clk from strobe sampled high.
  - Address uses row/col counters, no divider: col increments, wraps at COLS-1 to 0 and increments row.
- Index rules on an edge:
  - new_frame=1: write goes to (0,0), next index 1. If the index was not 0, err_cnt++ (resync).
  - index = ROWS*COLS-1 without new_frame: write, frame_done pulses the next cycle, frame_cnt++, index 0, go to IDLE.
  - Otherwise: index+1, state RECV.
  - A byte arriving at index 0 with new_frame=0 is accepted as byte 0. This is not an error.
- Timeout: a counter resets on every edge and counts only in RECV. At TIMEOUT cycles it sets index 0, err_cnt++, state IDLE, with no write.
- Simultaneous frame end and timeout are impossible, since the counter clears on the edge.
- err_cnt saturates at 255; frame_cnt wraps 65535->0.
- Reset asserted mid-sweep or mid-frame aborts immediately. After release a full CLEAR runs again.

Test Plan:
- Release reset -> 140 consecutive wr_en pulses, wr_data=0, addresses (0,0)..(9,13), busy high 140 cycles, then IDLE.
- 100 strobe edges with new_frame on the first, data=index -> byte 37 written at (3,7) with data 0x25; frame_done one cycle after byte 99; frame_cnt=1, err_cnt=0.
- new_frame asserted on the 42nd byte of a frame -> write to (0,0), err_cnt=1, the following byte lands at (0,1).
- Stall after byte 50 for TIMEOUT cycles -> err_cnt=1, no write; the next byte (new_frame=0) lands at (0,0).
- clear_req rise on the same cycle as a strobe edge -> that byte is not written; the sweep starts the next cycle; strobes during the sweep are ignored; err_cnt unchanged.
- Force 300 resync errors -> err_cnt stays at 255.
